pop_scheduler: RTL
==================

# pop_scheduler

Weighted round-robin pop scheduler for the four output FIFOs (S0..S3) of the transaction datapath. Each cycle it selects at most one FIFO that is non-empty and whose sink is ready, then asserts that FIFO's bit of the one-hot pop vector. Selection uses a per-FIFO burst weight, and an almost-full FIFO can override the normal rotation. The block replaces the bench-driven pop vector, and its `pop` output connects directly to the datapath's 4-bit pop input.

## Interface
- `WEIGHT_W`, 2: bits per FIFO weight field. A FIFO with weight w may take up to w+1 consecutive pops.
- `COUNT_W`, 8: width of the total-pop counter.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high.
- `init`  in  1  — configuration request; gates pops while high.
- `weight_cfg`  in  4*WEIGHT_W  — weight of FIFO i at bits [i*WEIGHT_W +: WEIGHT_W].
- `fifo_empty`  in  4  — empty flag per FIFO.
- `fifo_almost_full`  in  4  — almost-full flag per FIFO; marks the FIFO urgent.
- `sink_ready`  in  4  — downstream can accept a word from FIFO i.
- `pop`  out  4  — one-hot or zero; combinational.
- `pop_valid`  out  1  — equals `|pop`.
- `grant_idx`  out  2  — index of the popped FIFO; 0 when `pop_valid`=0.
- `state`  out  2  — FSM state, registered.
- `grant_count`  out  COUNT_W  — total pops issued; registered; wraps.

## Operation
- FSM encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- RESET → INIT on the first cycle with `reset`=0.
- INIT: while `init`=1, the weight register loads `weight_cfg` every cycle, so the last sampled value wins. INIT → IDLE on a cycle with `init`=0.
- IDLE/ACTIVE → INIT on any cycle with `init`=1. Otherwise the next state is ACTIVE if a pop was issued this cycle, else IDLE.
- Pops are allowed only when state ∈ {IDLE, ACTIVE} and `init`=0. No pop is ever issued in RESET or INIT.
- Eligibility: `elig[i] = !fifo_empty[i] && sink_ready[i]`. Urgency: `urg[i] = elig[i] && fifo_almost_full[i]`.
- Internal state: `ptr` (2 bits, the current owner) and `burst` (WEIGHT_W+1 bits, pops granted to `ptr` in the current burst).
- Selection order:
  1. If any `urg[i]`: grant the first urgent index scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  2. Else, if `elig[ptr]` and `burst` ≤ `weight[ptr]`: grant `ptr`.
  3. Else: grant the first eligible index scanning ptr+1, ptr+2, ptr+3, ptr.
- On a grant to index j: if j≠ptr, set `ptr`←j and `burst`←1. If j=ptr, `burst`←burst+1, saturating at its maximum value.
  - Rule 3 landing back on `ptr` (it is the only eligible FIFO) restarts the burst: `burst`←1.
- `grant_count` increments by 1 per pop, modulo 2^COUNT_W.
- Reset values: `state`=0, `grant_count`=0, weights=0, `ptr`=3, `burst`=all ones. With these values the first grant after reset goes to the lowest eligible index starting from 0.
- Derived from the reset values: `pop`=0, `pop_valid`=0, `grant_idx`=0.
- `reset` mid-operation forces all registers to their reset values at the next edge. A pending burst is discarded.

## Timing
- `pop`, `pop_valid` and `grant_idx` are combinational, zero latency from the inputs and registered state. `pop[i]`=1 implies `elig[i]`=1 in the same cycle.
- `ptr`, `burst`, `grant_count` and `state` update at the edge that ends a pop cycle. `state` therefore lags `pop_valid` by one cycle.
- Rising `init` suppresses `pop` in that same cycle.
- At most one pop per cycle. Sustained throughput is 1 pop per cycle while any FIFO is eligible.
- Boundary conditions:
  - All FIFOs empty or no sink ready: `pop`=0; state goes to IDLE at the next edge.
  - A FIFO becoming empty mid-burst: rotation moves on in the same cycle.
  - Several urgent FIFOs: they rotate among themselves and starve non-urgent FIFOs until no FIFO is urgent.

## Test plan
- Reset, `init`=1 for one cycle with `weight_cfg`=8'h00, then all FIFOs non-empty and `sink_ready`=4'hF → `pop` = 0001, 0010, 0100, 1000, 0001; `grant_count`=4 after the first four pops; `state`=3 from the second pop cycle.
- `weight_cfg`=8'h02 (w0=2), all eligible → `pop` = 0001×3, 0010, 0100, 1000, 0001×3.
- Only FIFO1 non-empty (`fifo_empty`=4'b1101) → `pop`=0010 every cycle with `grant_idx`=1. Then `fifo_empty`=4'hF → `pop`=0 that cycle and `state`=2 the next cycle.
- During FIFO0's burst with w0=3, raise `fifo_almost_full[2]` → next `pop`=0100 and continues 0100 while FIFO2 stays urgent. On deassertion, rotation resumes at FIFO3.
- `sink_ready`=4'b1101 with all FIFOs non-empty → FIFO1 is never popped; sequence is 0001, 0100, 1000.
- Mid-ACTIVE with `grant_count`=5: assert `init` → `pop`=0 in the same cycle and `state`=1 at the next edge. Separately, assert `reset` → at the next edge `state`=0 and `grant_count`=0, and the first pop after re-init is FIFO0.

Source files
------------

// File: rtl/pop_scheduler.sv
// Weighted round-robin pop scheduler for the four output FIFOs S0..S3.
// Issues at most one one-hot pop per cycle; almost-full FIFOs override the normal rotation.
module pop_scheduler #(
    parameter int WEIGHT_W = 2,
    parameter int COUNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [4*WEIGHT_W-1:0] weight_cfg,
    input  logic [3:0]            fifo_empty,
    input  logic [3:0]            fifo_almost_full,
    input  logic [3:0]            sink_ready,
    output logic [3:0]            pop,
    output logic                  pop_valid,
    output logic [1:0]            grant_idx,
    output logic [1:0]            state,
    output logic [COUNT_W-1:0]    grant_count
);

    localparam int BURST_W = WEIGHT_W + 1;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [4*WEIGHT_W-1:0] r_weight;
    logic [1:0]            r_ptr;
    logic [BURST_W-1:0]    r_burst;
    logic [COUNT_W-1:0]    r_count;

    logic [3:0]            w_elig;
    logic [3:0]            w_urg;
    logic                  w_pop_en;
    logic [WEIGHT_W-1:0]   w_cur_weight;
    logic [2:0]            w_urg_sel;
    logic [2:0]            w_elig_sel;
    logic                  w_grant;
    logic [1:0]            w_gidx;
    logic                  w_restart;

    // Returns {found, index} of the first request scanning ptr+1, ptr+2, ptr+3, ptr.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_elig       = ~fifo_empty & sink_ready;
    assign w_urg        = w_elig & fifo_almost_full;
    assign w_pop_en     = ((r_state == ST_IDLE) || (r_state == ST_ACTIVE)) && !init;
    assign w_cur_weight = r_weight[r_ptr*WEIGHT_W +: WEIGHT_W];
    assign w_urg_sel    = rr_pick(w_urg, r_ptr);
    assign w_elig_sel   = rr_pick(w_elig, r_ptr);

    always_comb begin
        w_grant   = 1'b0;
        w_gidx    = 2'd0;
        w_restart = 1'b0;
        if (w_pop_en) begin
            if (w_urg_sel[2]) begin
                w_grant = 1'b1;
                w_gidx  = w_urg_sel[1:0];
            end else if (w_elig[r_ptr] && (r_burst <= BURST_W'(w_cur_weight))) begin
                w_grant = 1'b1;
                w_gidx  = r_ptr;
            end else if (w_elig_sel[2]) begin
                w_grant   = 1'b1;
                w_gidx    = w_elig_sel[1:0];
                // Falling through to the owner means it is the only one left: new burst.
                w_restart = (w_elig_sel[1:0] == r_ptr);
            end
        end
    end

    assign pop         = w_grant ? (4'b0001 << w_gidx) : 4'b0000;
    assign pop_valid   = w_grant;
    assign grant_idx   = w_gidx;
    assign state       = r_state;
    assign grant_count = r_count;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RESET:  w_state_nxt = ST_INIT;
            ST_INIT:   w_state_nxt = init ? ST_INIT : ST_IDLE;
            default:   w_state_nxt = init ? ST_INIT : (w_grant ? ST_ACTIVE : ST_IDLE);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_weight <= '0;
            r_ptr    <= 2'd3;
            r_burst  <= '1;
            r_count  <= '0;
        end else begin
            if ((r_state == ST_INIT) && init) begin
                r_weight <= weight_cfg;
            end
            if (w_grant) begin
                r_count <= r_count + 1'b1;
                if ((w_gidx != r_ptr) || w_restart) begin
                    r_ptr   <= w_gidx;
                    r_burst <= BURST_W'(1);
                end else if (r_burst != '1) begin
                    r_burst <= r_burst + 1'b1;
                end
            end
        end
    end

endmodule
